// File: rtl/serial_byte_rx.sv
// Serial byte receiver: 8N1 framing, LSB first, mid-bit sampling after a
// two-flop synchronizer. Reports good bytes and bad stop bits as one-cycle strobes.
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_m, rx_s;
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          dv_n, fe_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Mid-bit re-check rejects glitches shorter than half a bit
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        data_n = shift;
                        dv_n   = 1'b1;
                    end else begin
                        fe_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            data       <= data_n;
            data_valid <= dv_n;
            frame_err  <= fe_n;
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Randomized bench for serial_byte_rx: frames are scheduled as expected events
// (strobe cycle, kind, byte) plus an expected-busy map, checked every cycle.
module tb_serial_byte_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
    localparam int MAXC = 16000;
    // 2 synchronizer flops + 1 IDLE detection cycle between line edge and START
    localparam int LAT  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid, frame_err, busy;

    serial_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        bit          ok;
        logic [7:0]  b;
    } ev_t;

    ev_t        q[$];
    logic [1:0] busy_exp [0:MAXC-1];
    logic [7:0] model_data = 8'h00;
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark(input int unsigned lo, input int unsigned hi, input logic [1:0] v);
        for (int unsigned c = lo; c < hi && c < MAXC; c++) busy_exp[c] = v;
    endtask

    // One 8N1 frame; a bad stop leaves the line low for a full bit, which the
    // receiver may briefly take as a start, so busy is a don't-care right after.
    task automatic send_frame(input logic [7:0] b, input bit ok);
        int unsigned k, s, e;
        logic [9:0]  lv;
        ev_t         ev;
        k = cyc;
        s = k + LAT;
        e = s + HALF + 9 * CPB;
        ev.cyc = e;
        ev.ok  = ok;
        ev.b   = b;
        q.push_back(ev);
        mark(s, e, 2'd1);
        if (!ok) mark(e, e + CPB, 2'd2);
        lv = {ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = lv[i];
            tick(CPB);
        end
        rx = 1'b1;
        if (!ok) tick(CPB);
    endtask

    task automatic glitch();
        int unsigned k;
        k = cyc;
        mark(k + LAT, k + LAT + HALF, 2'd1);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(CPB + 1);
    endtask

    always @(negedge clk) begin
        bit         edv, efe;
        logic [1:0] eb;
        ev_t        ev;
        edv = 1'b0;
        efe = 1'b0;
        if (!reset) begin
            model_data = 8'h00;
        end else if (q.size() != 0 && q[0].cyc == cyc) begin
            ev = q.pop_front();
            if (ev.ok) begin
                edv        = 1'b1;
                model_data = ev.b;
            end else begin
                efe = 1'b1;
            end
        end
        eb = (!reset || cyc >= MAXC) ? 2'd0 : busy_exp[cyc];
        check("data_valid", 32'(data_valid), 32'(edv));
        check("frame_err", 32'(frame_err), 32'(efe));
        check("data", 32'(data), 32'(model_data));
        check("strobe_excl", 32'(data_valid & frame_err), 32'd0);
        if (eb != 2'd2) check("busy", 32'(busy), 32'(eb));
    end

    initial begin
        int         r;
        logic [9:0] lv;
        for (int c = 0; c < MAXC; c++) busy_exp[c] = 2'd0;
        reset = 1'b0;
        rx    = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(5);

        // Bad stop bit straight after reset: data must stay 00
        send_frame(8'h5A, 1'b0);
        tick(2);
        glitch();
        send_frame(8'hA5, 1'b1);
        tick(3);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(4);

        // Abort 8'hFF after its bit 3 has been sampled
        lv = {1'b1, 8'hFF, 1'b0};
        mark(cyc + LAT, cyc + LAT + HALF + 9 * CPB, 2'd1);
        for (int i = 0; i < 5; i++) begin
            rx = lv[i];
            tick(CPB);
        end
        tick(2);
        check("busy_pre_rst", 32'(busy), 32'd1);
        #1;
        q.delete();
        mark(cyc, MAXC, 2'd0);
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rx = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(CPB);
        send_frame(8'h81, 1'b1);
        tick(1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(2);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) glitch();
            else send_frame(8'($urandom_range(0, 255)), r > 2);
            tick($urandom_range(0, 3));
        end

        tick(10);
        check("pending_events", 32'(q.size()), 32'd0);
        check("cycle_budget", 32'(cyc < MAXC), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
